gpcfg_ahb_wr_decode: RTL

AHB-Lite subordinate front-end for the general-purpose configuration register bank. It accepts AHB transfers, turns writes into a registered single-cycle write strobe with index, byte enables and data toward the register bank, and turns reads into `rd_en`/`rd_idx` plus the `valid_rd` qualifier consumed by the bank's read-data OR-mux. It also drives `hreadyout`/`hresp`, including wait states and two-cycle ERROR responses. It is the request/write side of the bus that the read-data mux completes.

---
 rtl/gpcfg_ahb_wr_decode.sv | 131 +++++++++++++
 1 files changed

// File: rtl/gpcfg_ahb_wr_decode.sv
// AHB-Lite request/write front-end for the gpcfg register bank: write strobes, read selects, wait/ERROR responses.
// Optional feature macro: GPCFG_WR_PROT_EN (rejects unprivileged writes).
module gpcfg_ahb_wr_decode #(
  parameter int NUM_REGS = 1024,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic             hclk,
  input  logic             hresetn,
  input  logic             hsel,
  input  logic             hready,
  input  logic [1:0]       htrans,
  input  logic [31:0]      haddr,
  input  logic             hwrite,
  input  logic [2:0]       hsize,
  input  logic [3:0]       hprot,
  input  logic [31:0]      hwdata,
  output logic             hreadyout,
  output logic             hresp,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_idx,
  output logic [3:0]       wr_be,
  output logic [31:0]      wr_data,
  output logic             rd_en,
  output logic [IDX_W-1:0] rd_idx,
  output logic             valid_rd
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD0, S_RD1, S_RD2, S_ERR1, S_ERR2} state_t;

  state_t           state;
  logic [IDX_W-1:0] pend_idx;
  logic [3:0]       pend_be;

  logic             accept, bad, size_bad, mis_bad, range_bad, prot_bad;
  logic [IDX_W-1:0] idx;
  logic [3:0]       be;
  logic             unused_bits;

  assign accept    = hsel & hready & htrans[1];
  assign idx       = haddr[IDX_W+1:2];
  assign size_bad  = hsize > 3'd2;
  assign mis_bad   = ((hsize == 3'd1) & haddr[0]) | ((hsize == 3'd2) & (haddr[1:0] != 2'b00));
  // Compare the full word address so aliases above the bank are rejected, not wrapped.
  assign range_bad = {2'b00, haddr[31:2]} >= 32'(NUM_REGS);
`ifdef GPCFG_WR_PROT_EN
  assign prot_bad  = hwrite & ~hprot[1];
`else
  assign prot_bad  = 1'b0;
`endif
  assign bad         = size_bad | mis_bad | range_bad | prot_bad;
  assign unused_bits = ^{htrans[0], hprot};

  always_comb begin
    be = 4'b0000;
    case (hsize)
      3'd0:    be = 4'b0001 << haddr[1:0];
      3'd1:    be = haddr[1] ? 4'b1100 : 4'b0011;
      3'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state     <= S_IDLE;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      wr_en     <= 1'b0;
      wr_idx    <= '0;
      wr_be     <= 4'b0000;
      wr_data   <= 32'h0;
      rd_en     <= 1'b0;
      rd_idx    <= '0;
      valid_rd  <= 1'b0;
      pend_idx  <= '0;
      pend_be   <= 4'b0000;
    end else begin
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      valid_rd  <= 1'b0;
      hresp     <= 1'b0;
      hreadyout <= 1'b1;
      if (state == S_WR) begin
        wr_en   <= 1'b1;
        wr_idx  <= pend_idx;
        wr_be   <= pend_be;
        wr_data <= hwdata;
      end
      case (state)
        S_RD0: begin
          state     <= S_RD1;
          hreadyout <= 1'b0;
          rd_en     <= 1'b1;
          valid_rd  <= 1'b1;
        end
        S_RD1:  state <= S_RD2;
        S_ERR1: begin
          state <= S_ERR2;
          hresp <= 1'b1;
        end
        // IDLE, WR, RD2, ERR2 are the ready states that can take a new transfer.
        default: begin
          if (accept) begin
            if (bad) begin
              state     <= S_ERR1;
              hreadyout <= 1'b0;
              hresp     <= 1'b1;
            end else if (hwrite) begin
              state    <= S_WR;
              pend_idx <= idx;
              pend_be  <= be;
            end else begin
              rd_idx    <= idx;
              hreadyout <= 1'b0;
              if (state == S_WR) begin
                state <= S_RD0;
              end else begin
                state    <= S_RD1;
                rd_en    <= 1'b1;
                valid_rd <= 1'b1;
              end
            end
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
